// File: rtl/segment_unit_if.sv
// Request/write/result bundle between the decoder/EU (master) and segment_unit (slave).
// The clock and reset stay outside the bundle as plain module ports.
interface segment_unit_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned SEL_W  = 2,
    parameter int unsigned ADDR_W = 20
);
    logic              wr_en;
    logic [SEL_W-1:0]  wr_sel;
    logic [DATA_W-1:0] wr_data;
    logic              req_valid;
    logic              req_ready;
    logic [SEL_W-1:0]  req_sel;
    logic [DATA_W-1:0] req_offset;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_seg;
    logic              sel_err;

    modport master (
        output wr_en, wr_sel, wr_data,
        output req_valid, req_sel, req_offset, out_ready,
        input  req_ready, out_valid, out_addr, out_seg, sel_err
    );

    modport slave (
        input  wr_en, wr_sel, wr_data,
        input  req_valid, req_sel, req_offset, out_ready,
        output req_ready, out_valid, out_addr, out_seg, sel_err
    );
endinterface

// File: rtl/segment_unit.sv
// Segment register file feeding a 2-stage valid/ready pipeline that forms
// (segment << SHIFT) + offset physical addresses and reports the segment used.
module segment_unit #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned NUM_SEG = 4,
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned SHIFT   = 4,
    parameter int unsigned ADDR_W  = 20
) (
    input logic           clk,
    input logic           rst,
    segment_unit_if.slave bus
);

    localparam int unsigned    SumW    = DATA_W + SHIFT + 1;
    localparam logic [SEL_W:0] NumSegW = (SEL_W + 1)'(NUM_SEG);

    logic [DATA_W-1:0] seg_q [NUM_SEG];

    logic              s1_valid_q;
    logic [DATA_W-1:0] s1_seg_q;
    logic [DATA_W-1:0] s1_off_q;
    logic              out_valid_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic [DATA_W-1:0] out_seg_q;
    logic              sel_err_q;

    logic              wr_in_range;
    logic              req_in_range;
    logic              advance;
    logic              req_ready;
    logic              accept;
    logic [DATA_W-1:0] req_seg;
    logic [ADDR_W-1:0] addr_d;

    assign wr_in_range  = {1'b0, bus.wr_sel} < NumSegW;
    assign req_in_range = {1'b0, bus.req_sel} < NumSegW;

    // Stage 2 (and stage 1 behind it) moves whenever the result slot is free or being taken.
    assign advance   = !out_valid_q || bus.out_ready;
    assign req_ready = !rst && (!s1_valid_q || advance);
    assign accept    = bus.req_valid && req_ready;

    // Write-first: a same-cycle write to the requested segment wins over the stored value.
    always_comb begin
        req_seg = '0;
        if (req_in_range) begin
            if (bus.wr_en && (bus.wr_sel == bus.req_sel)) begin
                req_seg = bus.wr_data;
            end else begin
                req_seg = seg_q[bus.req_sel];
            end
        end
    end

    // The inner add cannot overflow SumW; the outer cast truncates or zero-extends.
    assign addr_d = ADDR_W'(SumW'({s1_seg_q, {SHIFT{1'b0}}}) + SumW'(s1_off_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_SEG); i++) begin
                seg_q[i] <= '0;
            end
        end else if (bus.wr_en && wr_in_range) begin
            seg_q[bus.wr_sel] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_seg_q    <= '0;
            s1_off_q    <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_seg_q   <= '0;
            sel_err_q   <= 1'b0;
        end else begin
            // One pulse even if both ports carry a bad selector in the same cycle.
            sel_err_q <= (bus.wr_en && !wr_in_range) || (accept && !req_in_range);

            if (accept) begin
                s1_valid_q <= 1'b1;
                s1_seg_q   <= req_seg;
                s1_off_q   <= bus.req_offset;
            end else if (advance) begin
                s1_valid_q <= 1'b0;
            end

            if (advance) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_addr_q <= addr_d;
                    out_seg_q  <= s1_seg_q;
                end
            end
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_seg   = out_seg_q;
    assign bus.sel_err   = sel_err_q;

endmodule
